// File: rtl/key_input.sv
// key_input: per-key pushbutton conditioning. Each key has a 2-flop synchronizer, a debounce/hold FSM and a short-press toggle latch.
// Latency: a press or release edge on keys_n shows on the outputs DEBOUNCE_CYCLES+3 clocks later. long_pulse fires LONG_CYCLES clocks after press_pulse.
// Backpressure: none. Every output is a registered level or a one-cycle strobe, and downstream logic must sample it every cycle.
//
// Ports:
//   clk_50M        system clock, rising edge
//   rst            synchronous active-high reset
//   keys_n         raw active-low pushbuttons, asynchronous to clk_50M
//   key_level      debounced level, 1 = pressed
//   press_pulse    one-cycle strobe when a press is accepted
//   release_pulse  one-cycle strobe when a release is accepted
//   long_pulse     one-cycle strobe when a held key reaches LONG_CYCLES
//   toggle_state   flips on the release of each short press
module key_input #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] toggle_state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    LONG       = 3'd3,
    DB_RELEASE = 3'd4
  } state_e;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic          s1_q;
    logic          s2_q;
    state_e        state_q;
    logic [DW-1:0] dcnt_q;
    logic [HW-1:0] hcnt_q;
    logic          was_long_q;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          toggle_q;

    always_ff @(posedge clk_50M) begin
      if (rst) begin
        // The synchronizer resets to the released level so that a key held
        // through reset is seen as a fresh press afterwards.
        s1_q       <= 1'b1;
        s2_q       <= 1'b1;
        state_q    <= IDLE;
        dcnt_q     <= '0;
        hcnt_q     <= '0;
        was_long_q <= 1'b0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
        toggle_q   <= 1'b0;
      end else begin
        s1_q      <= keys_n[k];
        s2_q      <= s1_q;
        // The strobes default low, so each one is exactly one cycle wide.
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;

        case (state_q)
          IDLE: begin
            if (!s2_q) begin
              state_q <= DB_PRESS;
              dcnt_q  <= '0;
            end
          end

          DB_PRESS: begin
            if (s2_q) begin
              state_q <= IDLE;
            end else if (dcnt_q == DB_LAST) begin
              state_q    <= PRESSED;
              level_q    <= 1'b1;
              press_q    <= 1'b1;
              hcnt_q     <= '0;
              was_long_q <= 1'b0;
            end else begin
              dcnt_q <= dcnt_q + DW'(1);
            end
          end

          PRESSED: begin
            if (s2_q) begin
              state_q <= DB_RELEASE;
              dcnt_q  <= '0;
            end else if (hcnt_q == HOLD_LAST) begin
              state_q    <= LONG;
              long_q     <= 1'b1;
              was_long_q <= 1'b1;
            end else begin
              hcnt_q <= hcnt_q + HW'(1);
            end
          end

          // hcnt stops counting in LONG, so only one long_pulse fires per press.
          LONG: begin
            if (s2_q) begin
              state_q <= DB_RELEASE;
              dcnt_q  <= '0;
            end
          end

          // hcnt is left untouched here. A release bounce therefore resumes
          // the hold count where it stopped instead of restarting it.
          DB_RELEASE: begin
            if (!s2_q) begin
              state_q <= was_long_q ? LONG : PRESSED;
            end else if (dcnt_q == DB_LAST) begin
              state_q   <= IDLE;
              level_q   <= 1'b0;
              release_q <= 1'b1;
              if (!was_long_q) begin
                toggle_q <= ~toggle_q;
              end
            end else begin
              dcnt_q <= dcnt_q + DW'(1);
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end

    assign key_level[k]     = level_q;
    assign press_pulse[k]   = press_q;
    assign release_pulse[k] = release_q;
    assign long_pulse[k]    = long_q;
    assign toggle_state[k]  = toggle_q;
  end

endmodule

// File: doc/key_input.md
# key_input

Debounced push-button input block for the board's LED demo designs; it produces clean key levels and event pulses from raw pushbuttons. It sits on the input side of the LED pattern generators. Each key has:
- a 2-flop synchronizer;
- a debounce/hold state machine;
- a per-key toggle latch that can drive a pattern block's enable input directly.

## Interface
- N_KEYS, 4, number of independent keys
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a press or release (20 ms at 50 MHz); must be ≥ 2
- LONG_CYCLES, 50000000, cycles a key must stay in PRESSED before a long-press event (1 s at 50 MHz); must be ≥ 2
- clk_50M  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- keys_n  input  N_KEYS  raw pushbuttons, active-low, asynchronous to clk_50M
- key_level  output  N_KEYS  debounced state, 1 = pressed
- press_pulse  output  N_KEYS  one-cycle strobe when a press is accepted
- release_pulse  output  N_KEYS  one-cycle strobe when a release is accepted
- long_pulse  output  N_KEYS  one-cycle strobe when a held key reaches LONG_CYCLES
- toggle_state  output  N_KEYS  flips on release of each short press (not after long press)

## Operation
- Synchronizer: keys_n → s1 → s2, both reset to 1 (released). FSM sees only s2.
- Per key, independent FSM. Counters: dcnt of width $clog2(DEBOUNCE_CYCLES); hcnt of width $clog2(LONG_CYCLES); a 1-bit `was_long` flag.
- IDLE
  - If s2 == 0, go to DB_PRESS with dcnt = 0.
- DB_PRESS
  - If s2 == 1, return to IDLE (glitch rejected, no output).
  - Else if dcnt == DEBOUNCE_CYCLES-1: go to PRESSED, set key_level = 1, pulse press_pulse, and clear hcnt and was_long.
  - Else increment dcnt.
- PRESSED
  - If s2 == 1, go to DB_RELEASE with dcnt = 0.
  - Else if hcnt == LONG_CYCLES-1: go to LONG, pulse long_pulse, set was_long = 1.
  - Else increment hcnt.
- LONG
  - If s2 == 1, go to DB_RELEASE with dcnt = 0. hcnt does not count.
- DB_RELEASE
  - hcnt is frozen.
  - If s2 == 0, return to PRESSED (was_long = 0) or LONG (was_long = 1) with hcnt preserved.
  - Else if dcnt == DEBOUNCE_CYCLES-1: go to IDLE, set key_level = 0, pulse release_pulse, and flip toggle_state if was_long == 0.
  - Else increment dcnt.
- key_level stays 1 throughout PRESSED, LONG and DB_RELEASE.
- Exactly one long_pulse per press, regardless of hold duration.
- Counters never wrap; they saturate by state exit.
- Keys are fully independent. Simultaneous events on different keys assert their respective bits in the same cycle.

## Timing
- Reset values: all outputs 0, s1/s2 = all 1s, all FSMs in IDLE, counters 0.
- rst asserted mid-operation returns every key to IDLE on the next edge:
  - no release_pulse is generated;
  - toggle_state clears.
- All outputs are registered. Pulses are exactly one cycle wide.
- Press latency: keys_n falls before edge 0 (stable thereafter). Then:
  - s1 at edge 1, s2 at edge 2;
  - DB_PRESS entered at edge 3;
  - press_pulse and key_level rise after edge DEBOUNCE_CYCLES+3.
- Long latency: long_pulse asserts LONG_CYCLES edges after press_pulse, provided no DB_RELEASE detour occurs.
- Release latency: symmetric with press. release_pulse asserts DEBOUNCE_CYCLES+3 edges after keys_n rises. toggle_state changes in the same cycle as release_pulse.
- Any bounce restarts the debounce count:
  - in DB_PRESS, a one-cycle s2 = 1 resets to IDLE;
  - in DB_RELEASE, a one-cycle s2 = 0 returns to the held state.

## Test plan
Bench overrides: DEBOUNCE_CYCLES = 4, LONG_CYCLES = 10, N_KEYS = 4.
- Reset: hold rst 3 cycles with keys_n = 4'b0000 → all outputs 0. After release, key_level = 4'b1111 with press_pulse = 4'b1111 exactly at edge 7 after rst deasserts.
- Clean short press on key0: keys_n[0] low 20 cycles, then high.
  - press_pulse[0] for one cycle at edge 7;
  - release_pulse[0] at edge 7 after the rise;
  - toggle_state[0] 0 → 1;
  - no long_pulse.
- Bounce rejection: keys_n[1] low 3 cycles, high 1, low 3, high → no pulse, key_level[1] stays 0.
- Long press on key2: held 30 cycles.
  - press_pulse at edge 7, long_pulse at edge 17 (single);
  - release_pulse after release;
  - toggle_state[2] unchanged.
- Release bounce: key3 held, then one high cycle mid-hold → no release_pulse, key_level[3] stays 1, hcnt resumes.
- Simultaneous + reset: keys 0 and 3 pressed on the same cycle → both press_pulse bits in the same cycle. rst asserted while both held → outputs 0 next cycle, no release_pulse.
